// File: rtl/video_pkg.sv
// Shared pixel-stream definitions for the video filter pipeline.
package video_pkg;

  localparam int unsigned PIX_W        = 24;
  localparam int unsigned H_ACTIVE_DEF = 640;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;

endpackage

// File: rtl/line_buffer.sv
// Single-address line buffer: combinational read of the addressed word, write on enable.
// A read and a write to the same address in one cycle return the old word.
module line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 RGB neighbourhood generator: two line buffers feed a 3x3 tap register window;
// DE_OUT marks windows that lie fully inside the current frame.
module window_3x3_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned PIX_W    = video_pkg::PIX_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VS_IN,
  input  logic             DE_IN,
  input  logic [PIX_W-1:0] DIN,
  output logic [PIX_W-1:0] D02,
  output logic [PIX_W-1:0] D01,
  output logic [PIX_W-1:0] D00,
  output logic [PIX_W-1:0] D12,
  output logic [PIX_W-1:0] D11,
  output logic [PIX_W-1:0] D10,
  output logic [PIX_W-1:0] D22,
  output logic [PIX_W-1:0] D21,
  output logic [PIX_W-1:0] D20,
  output logic             DE_OUT
);

  localparam int unsigned   CW       = $clog2(H_ACTIVE);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);

  logic [CW-1:0]    r_col;
  logic [1:0]       r_rows;
  logic             r_de;
  logic [CW-1:0]    w_addr;
  logic [PIX_W-1:0] w_lb1_q;
  logic [PIX_W-1:0] w_lb2_q;
  logic [PIX_W-1:0] r_d02, r_d01, r_d00, r_d12, r_d11, r_d10, r_d22, r_d21, r_d20;

  // A frame-start pixel lands at column 0 regardless of where the old line stopped.
  assign w_addr = VS_IN ? '0 : r_col;

  line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .i_clk   (CLK),
    .i_we    (DE_IN),
    .i_addr  (w_addr),
    .i_wdata (DIN),
    .o_rdata (w_lb1_q)
  );

  line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
    .i_clk   (CLK),
    .i_we    (DE_IN),
    .i_addr  (w_addr),
    .i_wdata (w_lb1_q),
    .o_rdata (w_lb2_q)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_col  <= '0;
      r_rows <= '0;
      r_de   <= 1'b0;
    end else if (VS_IN) begin
      r_col  <= DE_IN ? CW'(1) : '0;
      r_rows <= '0;
      r_de   <= 1'b0;
    end else begin
      r_de <= DE_IN & (r_rows == 2'd2) & (r_col >= CW'(2));
      if (DE_IN) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_rows != 2'd2) r_rows <= r_rows + 2'd1;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      {r_d02, r_d01, r_d00} <= '0;
      {r_d12, r_d11, r_d10} <= '0;
      {r_d22, r_d21, r_d20} <= '0;
    end else if (DE_IN) begin
      {r_d02, r_d01, r_d00} <= {r_d01, r_d00, w_lb2_q};
      {r_d12, r_d11, r_d10} <= {r_d11, r_d10, w_lb1_q};
      {r_d22, r_d21, r_d20} <= {r_d21, r_d20, DIN};
    end
  end

  assign D02    = r_d02;
  assign D01    = r_d01;
  assign D00    = r_d00;
  assign D12    = r_d12;
  assign D11    = r_d11;
  assign D10    = r_d10;
  assign D22    = r_d22;
  assign D21    = r_d21;
  assign D20    = r_d20;
  assign DE_OUT = r_de;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: a frame-image model predicts every 3x3 window.
module tb_window_3x3_gen;

  localparam int H = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        VS_IN = 1'b0;
  logic        DE_IN = 1'b0;
  logic [23:0] DIN = '0;
  logic [23:0] D02, D01, D00, D12, D11, D10, D22, D21, D20;
  logic        DE_OUT;
  logic [215:0] w_taps;

  int total = 0;
  int bad   = 0;
  int n_de  = 0;

  logic [215:0] q[$];
  logic [23:0]  img [64][H];
  int mrow = 0;
  int mcol = 0;

  window_3x3_gen #(.H_ACTIVE(H), .PIX_W(24)) dut (
    .CLK(CLK), .RESET(RESET), .VS_IN(VS_IN), .DE_IN(DE_IN), .DIN(DIN),
    .D02(D02), .D01(D01), .D00(D00),
    .D12(D12), .D11(D11), .D10(D10),
    .D22(D22), .D21(D21), .D20(D20),
    .DE_OUT(DE_OUT)
  );

  assign w_taps = {D02, D01, D00, D12, D11, D10, D22, D21, D20};

  always #5 CLK = ~CLK;

  function automatic logic [23:0] pf(int r, int c);
    return {8'(r), 8'(c), 8'(r + c)};
  endfunction

  task automatic check(string nm, logic [215:0] act, logic [215:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: store each accepted pixel at its frame position; a window exists
  // whenever the pixel sits at row>=2, col>=2, and consists of the 3x3 block ending there.
  task automatic drive(bit vs, bit de, logic [23:0] d);
    int r0, r1, r2;
    @(negedge CLK);
    VS_IN = vs;
    DE_IN = de;
    DIN   = d;
    if (vs) begin
      mrow = 0;
      mcol = 0;
    end
    if (de) begin
      img[mrow % 64][mcol] = d;
      if (mrow >= 2 && mcol >= 2) begin
        r0 = (mrow - 2) % 64;
        r1 = (mrow - 1) % 64;
        r2 = mrow % 64;
        q.push_back({img[r0][mcol-2], img[r0][mcol-1], img[r0][mcol],
                     img[r1][mcol-2], img[r1][mcol-1], img[r1][mcol],
                     img[r2][mcol-2], img[r2][mcol-1], img[r2][mcol]});
      end
      mcol++;
      if (mcol == H) begin
        mcol = 0;
        mrow++;
      end
    end
  endtask

  task automatic lines(int first, int rows, bit toggle);
    for (int r = first; r < first + rows; r++) begin
      for (int c = 0; c < H; c++) begin
        drive(1'b0, 1'b1, pf(r, c));
        if (toggle) drive(1'b0, 1'b0, 24'($urandom));
      end
    end
  endtask

  task automatic const_lines(int rows, logic [23:0] v);
    for (int i = 0; i < rows * H; i++) drive(1'b0, 1'b1, v);
  endtask

  task automatic drain(string nm);
    repeat (3) drive(1'b0, 1'b0, '0);
    check({nm, "_pending"}, 216'(q.size()), '0);
    q.delete();
  endtask

  initial begin
    logic [215:0] exp;
    forever begin
      @(posedge CLK);
      #2;
      if (DE_OUT === 1'b1) begin
        n_de++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_de_out act=1 exp=0");
        end else begin
          exp = q.pop_front();
          check("window", w_taps, exp);
        end
      end
    end
  end

  initial begin
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_taps", w_taps, '0);
    check("reset_de", 216'(DE_OUT), '0);
    RESET = 1'b1;

    // Full-rate stream: 6 windows per line on rows 2..4.
    n_de = 0;
    drive(1'b1, 1'b0, '0);
    lines(0, 5, 1'b0);
    drain("t1");
    check("t1_de_count", 216'(n_de), 216'(18));

    // DE_IN toggling between accepted pixels.
    n_de = 0;
    drive(1'b1, 1'b0, '0);
    lines(0, 5, 1'b1);
    drain("t2");
    check("t2_de_count", 216'(n_de), 216'(18));

    // VS mid-row 3, col 4, with DE_IN high: that pixel restarts the frame at (0,0).
    n_de = 0;
    drive(1'b1, 1'b0, '0);
    lines(0, 3, 1'b0);
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, pf(3, c));
    drive(1'b1, 1'b1, pf(0, 0));
    for (int c = 1; c < H; c++) drive(1'b0, 1'b1, pf(0, c));
    lines(1, 3, 1'b0);
    drain("t3");
    check("t3_de_count", 216'(n_de), 216'(20));

    // Asynchronous reset mid-line 3.
    drive(1'b1, 1'b0, '0);
    lines(0, 3, 1'b0);
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b1, pf(3, c));
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    check("async_reset_taps", w_taps, '0);
    check("async_reset_de", 216'(DE_OUT), '0);
    q.delete();
    mrow = 0;
    mcol = 0;
    DE_IN = 1'b0;
    VS_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    n_de = 0;
    drive(1'b1, 1'b0, '0);
    lines(0, 5, 1'b0);
    drain("t4");
    check("t4_de_count", 216'(n_de), 216'(18));

    // Ten lines: wrap at col 7, rows_filled saturates, cols 0/1 masked each line.
    n_de = 0;
    drive(1'b1, 1'b0, '0);
    lines(0, 10, 1'b0);
    drain("t5");
    check("t5_de_count", 216'(n_de), 216'(48));

    // All-ones frame followed by all-zeros frame.
    drive(1'b1, 1'b0, '0);
    const_lines(5, 24'hFFFFFF);
    drive(1'b1, 1'b0, '0);
    const_lines(5, 24'h000000);
    drain("t6");

    // Random pixels, random DE_IN gaps, occasional VS.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 24'($urandom));
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
